// File: rtl/tx_prbs_mapper.sv
// PRBS-driven 4-ASK symbol source: a Fibonacci LFSR feeds Gray-coded bit pairs
// into a 1s17 level mapper, with a period marker for the downstream averager.
module tx_prbs_mapper #(
   parameter int unsigned          LFSR_WID = 22,
   parameter logic [LFSR_WID-1:0]  TAPS     = 22'h300000,
   parameter logic [LFSR_WID-1:0]  SEED     = '1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sym_clk_en,
   input  logic                force_outer,
   output logic signed [17:0]  sym_out,
   output logic [1:0]          sym_bits,
   output logic                sym_valid,
   output logic                clr_acc
);

   localparam logic signed [17:0] LVL_INNER = 18'sd32768;
   localparam logic signed [17:0] LVL_OUTER = 18'sd98304;
   localparam logic [LFSR_WID-1:0] CNT_LAST = {{(LFSR_WID-1){1'b1}}, 1'b0};
   localparam logic [LFSR_WID-1:0] CNT_ONE  = {{(LFSR_WID-1){1'b0}}, 1'b1};

   // Gray pair to level: bit[1] is the sign, bit[0]=0 selects the outer ring.
   function automatic logic signed [17:0] map_symbol(input logic [1:0] pair,
                                                     input logic       outer);
      logic signed [17:0] mag;
      mag = (outer || !pair[0]) ? LVL_OUTER : LVL_INNER;
      return pair[1] ? mag : -mag;
   endfunction

   logic [LFSR_WID-1:0] lfsr_q, lfsr_d;
   logic [LFSR_WID-1:0] cnt_q, cnt_d;
   logic signed [17:0]  sym_out_q, sym_out_d;
   logic [1:0]          sym_bits_q, sym_bits_d;
   logic                sym_valid_q;
   logic                clr_acc_q, clr_acc_d;
   logic                fb;
   logic                lfsr_zero;
   logic                cnt_wrap;

   always_comb begin
      fb        = ^(lfsr_q & TAPS);
      lfsr_zero = (lfsr_q == '0);
      cnt_wrap  = (cnt_q == CNT_LAST);

      // An all-zero register would never leave zero; reload and emit pair 00.
      if (lfsr_zero) begin
         sym_bits_d = 2'b00;
         lfsr_d     = SEED;
      end else begin
         sym_bits_d = lfsr_q[LFSR_WID-1 -: 2];
         lfsr_d     = {lfsr_q[LFSR_WID-2:0], fb};
      end

      sym_out_d = map_symbol(sym_bits_d, force_outer);
      cnt_d     = cnt_wrap ? '0 : cnt_q + CNT_ONE;
      clr_acc_d = cnt_wrap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr_q      <= SEED;
         cnt_q       <= '0;
         sym_out_q   <= '0;
         sym_bits_q  <= 2'b00;
         sym_valid_q <= 1'b0;
         clr_acc_q   <= 1'b0;
      end else begin
         sym_valid_q <= sym_clk_en;
         if (sym_clk_en) begin
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            sym_out_q  <= sym_out_d;
            sym_bits_q <= sym_bits_d;
            clr_acc_q  <= clr_acc_d;
         end
      end
   end

   assign sym_out   = sym_out_q;
   assign sym_bits  = sym_bits_q;
   assign sym_valid = sym_valid_q;
   assign clr_acc   = clr_acc_q;

endmodule

// File: tb/tb_tx_prbs_mapper.sv
// Bench for tx_prbs_mapper on a 4-bit LFSR: fixed vectors, period/reset corner
// sequences, a zero-tap instance for the lock-up guard, and random strobes.
module tb_tx_prbs_mapper;

   localparam int         W      = 4;
   localparam logic [3:0] TAPS4  = 4'b1100;
   localparam logic [3:0] SEED4  = 4'b1111;
   localparam int         PERIOD = 15;

   logic clk, reset, en, fo, zen, zfo;
   logic signed [17:0] so, zo;
   logic [1:0] sb, zb;
   logic sv, ca, zv, zc;

   tx_prbs_mapper #(.LFSR_WID(W), .TAPS(TAPS4), .SEED(SEED4)) dut (
      .clk(clk), .reset(reset), .sym_clk_en(en), .force_outer(fo),
      .sym_out(so), .sym_bits(sb), .sym_valid(sv), .clr_acc(ca));

   // Zero taps shift in zeros, so the register reaches 0 after four symbols.
   tx_prbs_mapper #(.LFSR_WID(W), .TAPS(4'b0000), .SEED(SEED4)) u_zero (
      .clk(clk), .reset(reset), .sym_clk_en(zen), .force_outer(zfo),
      .sym_out(zo), .sym_bits(zb), .sym_valid(zv), .clr_acc(zc));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: state as an integer, feedback as parity of tapped bits.
   int unsigned        m_lfsr;
   int                 m_n;
   logic signed [17:0] m_out;
   logic [1:0]         m_bits;
   bit                 m_valid, m_clr;

   function automatic int level(input logic [1:0] pair, input bit outer);
      int l;
      case (pair)
         2'b00:   l = -3;
         2'b01:   l = -1;
         2'b11:   l = 1;
         default: l = 3;
      endcase
      if (outer) l = pair[1] ? 3 : -3;
      return l;
   endfunction

   task automatic model_step(input bit e, input bit f, input bit r);
      logic [1:0] pair;
      int unsigned fb;
      if (r) begin
         m_lfsr = SEED4; m_n = 0; m_out = '0; m_bits = 2'b00;
         m_valid = 1'b0; m_clr = 1'b0;
      end else begin
         m_valid = e;
         if (e) begin
            if (m_lfsr == 0) begin
               pair   = 2'b00;
               m_lfsr = SEED4;
            end else begin
               pair   = 2'((m_lfsr >> (W - 2)) & 3);
               fb     = $countones(m_lfsr & 32'(TAPS4)) % 2;
               m_lfsr = ((m_lfsr << 1) | fb) & ((1 << W) - 1);
            end
            m_bits = pair;
            m_out  = 18'(level(pair, f) * 32768);
            m_n++;
            m_clr  = (m_n % PERIOD) == 0;
         end
      end
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_in(input string nm, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic check_model(input string nm);
      chk({nm, ".sym_out"}, so, m_out);
      chk({nm, ".sym_bits"}, sb, m_bits);
      chk({nm, ".sym_valid"}, sv, m_valid);
      chk({nm, ".clr_acc"}, ca, m_clr);
   endtask

   task automatic step(input bit e, input bit f, input bit r, input bit ze);
      en = e; fo = f; reset = r; zen = ze;
      @(posedge clk); #1;
      model_step(e, f, r);
      en = 1'b0; zen = 1'b0; reset = 1'b0;
   endtask

   // One strobe followed by one idle clock, both checked against the model.
   task automatic strobe_chk(input bit f, input string nm);
      step(1'b1, f, 1'b0, 1'b0);
      check_model(nm);
      step(1'b0, f, 1'b0, 1'b0);
      check_model({nm, ".hold"});
   endtask

   typedef struct {
      logic signed [17:0] out;
      logic [1:0]         bits;
      logic [3:0]         lfsr;
   } vec_t;

   vec_t tv[5];
   vec_t zv_tab[6];
   logic signed [17:0] seq[30];
   longint sum_mag;
   int     sum_sq;

   initial begin
      tv[0] = '{18'sd32768,  2'b11, 4'b1111};
      tv[1] = '{18'sd32768,  2'b11, 4'b1110};
      tv[2] = '{18'sd32768,  2'b11, 4'b1100};
      tv[3] = '{18'sd98304,  2'b10, 4'b1000};
      tv[4] = '{-18'sd98304, 2'b00, 4'b0001};

      zv_tab[0] = '{18'sd32768,  2'b11, 4'b1111};
      zv_tab[1] = '{18'sd32768,  2'b11, 4'b1110};
      zv_tab[2] = '{18'sd32768,  2'b11, 4'b1100};
      zv_tab[3] = '{18'sd98304,  2'b10, 4'b1000};
      zv_tab[4] = '{-18'sd98304, 2'b00, 4'b0000};
      zv_tab[5] = '{18'sd32768,  2'b11, 4'b1111};

      en = 1'b0; fo = 1'b0; reset = 1'b1; zen = 1'b0; zfo = 1'b0;

      // Reset state, including a strobe that reset must override.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("rst.sym_out", so, 0);
      chk("rst.sym_bits", sb, 0);
      chk("rst.sym_valid", sv, 0);
      chk("rst.clr_acc", ca, 0);
      chk("rst.lfsr", dut.lfsr_q, SEED4);
      chk("rst.zero_inst_out", zo, 0);

      // Fixed vectors, strobes four clocks apart.
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("vec%0d.lfsr", i), dut.lfsr_q, tv[i].lfsr);
         step(1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d.sym_out", i), so, tv[i].out);
         chk($sformatf("vec%0d.sym_bits", i), sb, tv[i].bits);
         chk($sformatf("vec%0d.sym_valid", i), sv, 1);
         for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d.valid_low%0d", i, g), sv, 0);
            chk($sformatf("vec%0d.hold%0d", i, g), so, tv[i].out);
         end
      end

      // 30 strobes: clr_acc period, sequence periodicity, average power.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      sum_mag = 0; sum_sq = 0;
      for (int k = 0; k < 30; k++) begin
         strobe_chk(1'b0, $sformatf("per%0d", k + 1));
         seq[k] = so;
         if (k < PERIOD) begin
            sum_mag += (so < 0) ? -longint'(so) : longint'(so);
            sum_sq  += (longint'(so) / 32768) * (longint'(so) / 32768);
         end
         if (k == 14) chk("per.lfsr_at_wrap", dut.lfsr_q, SEED4);
         if (k >= PERIOD) chk($sformatf("per.repeat%0d", k + 1), seq[k], seq[k - PERIOD]);
      end
      chk_in("per.sum_abs", sum_mag, 983040 - 98304, 983040 + 98304);
      chk_in("per.sum_sq_quarters", sum_sq, 75 - 9, 75 + 9);

      // force_outer for one period, then released while idle.
      step(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < PERIOD; k++) begin
         strobe_chk(1'b1, $sformatf("fo%0d", k + 1));
         chk($sformatf("fo%0d.abs", k + 1), (so < 0) ? -longint'(so) : longint'(so), 98304);
         chk($sformatf("fo%0d.sign", k + 1), (so > 0) ? 1 : 0, sb[1]);
      end
      chk("fo.clr_at_15", ca, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check_model("fo.release_idle");

      // Reset mid-period while clr_acc is low.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 7; k++) strobe_chk(1'b0, $sformatf("mid%0d", k + 1));
      step(1'b0, 1'b0, 1'b1, 1'b0);
      check_model("mid.reset");
      chk("mid.reset_out", so, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid.restart_out", so, 32768);
      chk("mid.restart_clr", ca, 0);

      // Reset coinciding with the 15th strobe: clr_acc must not rise.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 14; k++) strobe_chk(1'b0, $sformatf("wr%0d", k + 1));
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check_model("wr.reset_on_15");
      chk("wr.clr_blocked", ca, 0);
      chk("wr.out_zero", so, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("wr.restart_out", so, 32768);
      chk("wr.restart_clr", ca, 0);

      // Lock-up guard on the zero-tap instance.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("lock%0d.lfsr", i), u_zero.lfsr_q, zv_tab[i].lfsr);
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk($sformatf("lock%0d.sym_out", i), zo, zv_tab[i].out);
         chk($sformatf("lock%0d.sym_bits", i), zb, zv_tab[i].bits);
         chk($sformatf("lock%0d.sym_valid", i), zv, 1);
         if (i == 4) chk("lock.reload_seed", u_zero.lfsr_q, SEED4);
      end

      // Random strobes, force toggles and occasional resets, checked every clock.
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 800; c++) begin
         step($urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 99) == 0, 1'b0);
         check_model($sformatf("rnd%0d", c));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tx_prbs_mapper.md
TX_PRBS_MAPPER -- requirements
Module: tx_prbs_mapper

Interface
REQ-001 SHALL have parameter LFSR_WID, default 22, LFSR length in bits (range 4..32).
REQ-002 SHALL have parameter TAPS, default 22'h300000 (x^22+x^21+1), LFSR_WID-bit feedback tap mask.
REQ-003 SHALL have parameter SEED, default all ones (LFSR_WID bits), nonzero LFSR reload value.
REQ-004 clk  input  1  system clock; all state SHALL change on posedge clk only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sym_clk_en  input  1  one-clk symbol strobe; all symbol-rate state SHALL advance only on clk edges where it is high.
REQ-007 force_outer  input  1  test mode; forces outer-level magnitude.
REQ-008 sym_out  output  18  signed 1s17 4-ASK symbol, registered.
REQ-009 sym_bits  output  2  Gray bit pair mapped to the current sym_out, registered.
REQ-010 sym_valid  output  1  one-clk pulse marking a sym_out update.
REQ-011 clr_acc  output  1  period marker for the downstream average-magnitude accumulator, registered.

Function
REQ-012 LFSR SHALL be Fibonacci: fb = XOR of lfsr bits selected by TAPS; on sym_clk_en, lfsr <= {lfsr[LFSR_WID-2:0], fb}.
REQ-013 Symbol bit pair SHALL be lfsr[LFSR_WID-1:LFSR_WID-2], sampled before the shift on the same edge.
REQ-014 Gray map: 00 -> -98304 (-0.75), 01 -> -32768 (-0.25), 11 -> +32768 (+0.25), 10 -> +98304 (+0.75).
REQ-015 When force_outer=1, magnitude SHALL be 98304; sign SHALL follow bit[1] (1 -> +, 0 -> -); sym_bits SHALL still carry the raw pair.
REQ-016 sym_out and sym_bits SHALL update on the same edge that samples sym_clk_en=1, with zero extra latency; otherwise they hold.
REQ-017 sym_valid SHALL be high for exactly the one clk cycle following each edge that updated sym_out.
REQ-018 Symbol counter sym_cnt (LFSR_WID bits) SHALL increment on each sym_clk_en and wrap to 0 on the edge where sym_cnt == 2^LFSR_WID-2, giving a period of 2^LFSR_WID-1 symbols.
REQ-019 On the wrap edge, clr_acc SHALL be set to 1; it SHALL clear on the next sym_clk_en edge, so it stays high for exactly one symbol period.
REQ-020 Lock-up guard: if lfsr == 0 on a sym_clk_en edge, lfsr SHALL reload SEED and the symbol for that edge SHALL use bits 00.
REQ-021 Over one full period in normal mode, average |sym_out| SHALL be 0.5 (65536) and mean square SHALL be 0.3125, within one-symbol imbalance.
REQ-022 force_outer changes SHALL take effect on the next sym_clk_en edge only; they SHALL NOT affect lfsr, sym_cnt or clr_acc.
REQ-023 Consecutive sym_clk_en pulses on back-to-back clks SHALL each advance state; no minimum spacing is required.

Reset
REQ-024 While reset=1: lfsr=SEED, sym_cnt=0, sym_out=0, sym_bits=00, sym_valid=0, clr_acc=0; sym_clk_en is ignored.
REQ-025 Reset SHALL override sym_clk_en on the same edge, including mid-period and during a high clr_acc.
REQ-026 The first sym_clk_en after reset release SHALL emit the symbol from SEED's top two bits.

Verification (LFSR_WID=4, TAPS=4'b1100, SEED=4'b1111 unless noted)
REQ-027 Reset, then 5 sym_clk_en strobes spaced 4 clks apart -> sym_out = +32768, +32768, +32768, +98304, -98304; lfsr states 1111, 1110, 1100, 1000, 0001; sym_valid pulses once per strobe, one clk after each update edge.
REQ-028 30 strobes -> clr_acc rises on the 15th strobe edge, falls on the 16th, rises again on the 30th; the symbol sequence repeats every 15 strobes.
REQ-029 force_outer=1 for 15 strobes -> every |sym_out| = 98304 and sign matches sym_bits[1]; clr_acc timing is identical to REQ-028.
REQ-030 Assert reset for 1 clk after the 7th strobe while clr_acc=0, and separately on the 15th strobe edge -> all outputs 0 and the next strobe yields +32768 (SEED restart); clr_acc does not rise on that edge.
REQ-031 Default parameters, 2^22-1 strobes back-to-back -> clr_acc high for exactly one symbol, sum |sym_out| = 65536 x (2^22-1) within ±98304, and lfsr equals SEED at the wrap.
REQ-032 Force lfsr=0 via bench hierarchical deposit, then 1 strobe -> sym_out = -98304, lfsr = SEED.
